// File: rtl/uart_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one UART among byte-stream sources.
// A grant lasts until the delimiter byte or a runaway-frame watchdog release.
module uart_frame_arbiter #(
  parameter int         NumSrc      = 2,
  parameter int         MaxFrameLen = 256,
  parameter logic [7:0] Delimiter   = 8'h00,
  localparam int        GW = (NumSrc > 1) ? $clog2(NumSrc) : 1,
  localparam int        CW = $clog2(MaxFrameLen + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NumSrc*8-1:0] src_data_i,
  input  logic [NumSrc-1:0]   src_have_next_i,
  output logic [NumSrc-1:0]   src_ack_o,
  output logic [7:0]          uart_d_o,
  output logic                uart_rts_o,
  input  logic                uart_next_i,
  output logic [GW-1:0]       grant_id_o,
  output logic                busy_o,
  output logic                overrun_o,
  input  logic                overrun_clr_i
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] last_q;
  logic [GW-1:0] win_id;
  logic          win_found;
  logic [CW-1:0] cnt_q;
  logic          ovr_q;

  logic          g_have;
  logic [7:0]    g_data;
  logic          accept;
  logic          is_delim;
  logic          at_limit;
  logic          force_rel;
  logic          release_frame;

  assign g_have = src_have_next_i[grant_q];
  assign g_data = src_data_i[8*grant_q +: 8];

  assign accept   = (state_q == LOCK) & g_have & uart_next_i;
  assign is_delim = (g_data == Delimiter);
  assign at_limit = (cnt_q == CW'(MaxFrameLen - 1));

  assign force_rel     = accept & ~is_delim & at_limit;
  assign release_frame = accept & (is_delim | at_limit);

  // Scan starts one past the last grant so every source gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 1; i <= NumSrc; i++) begin
      if (!win_found &&
          src_have_next_i[(int'(last_q) + i) % NumSrc]) begin
        win_found = 1'b1;
        win_id    = GW'((int'(last_q) + i) % NumSrc);
      end
    end
  end

  always_comb begin
    uart_d_o   = '0;
    uart_rts_o = 1'b0;
    src_ack_o  = '0;
    if (state_q == LOCK) begin
      uart_d_o           = g_data;
      uart_rts_o         = g_have;
      src_ack_o[grant_q] = accept;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (win_found) state_d = LOCK;
      end
      (state_q == LOCK): begin
        if (release_frame) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NumSrc - 1);
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && win_found) grant_q <= win_id;
      if (release_frame) begin
        last_q <= grant_q;
        cnt_q  <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (force_rel) ovr_q <= 1'b1;
      else if (overrun_clr_i) ovr_q <= 1'b0;
    end
  end

  assign grant_id_o = grant_q;
  assign busy_o     = (state_q == LOCK);
  assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Scoreboard bench for uart_frame_arbiter: directed frames, stalls,
// watchdog release and asynchronous reset.
module tb_uart_frame_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] src_data_i;
  logic [1:0]  src_have_next_i;
  logic [1:0]  src_ack_o;
  logic [7:0]  uart_d_o;
  logic        uart_rts_o;
  logic        uart_next_i;
  logic [0:0]  grant_id_o;
  logic        busy_o;
  logic        overrun_o;
  logic        overrun_clr_i;

  always #5 clk = ~clk;

  uart_frame_arbiter #(
    .NumSrc(2), .MaxFrameLen(4), .Delimiter(8'h00)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .src_data_i(src_data_i),
    .src_have_next_i(src_have_next_i),
    .src_ack_o(src_ack_o),
    .uart_d_o(uart_d_o),
    .uart_rts_o(uart_rts_o),
    .uart_next_i(uart_next_i),
    .grant_id_o(grant_id_o),
    .busy_o(busy_o),
    .overrun_o(overrun_o),
    .overrun_clr_i(overrun_clr_i)
  );

  typedef struct {
    logic [0:0] id;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] srcq[2][$];
  logic [1:0] stall;
  logic [1:0] ack_s;
  int         ack_cnt[2];
  int         pass_cnt = 0;
  int         chk_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic void drive();
    for (int k = 0; k < 2; k++) begin
      src_have_next_i[k] = (srcq[k].size() > 0) && !stall[k];
      src_data_i[8*k +: 8] = (srcq[k].size() > 0) ? srcq[k][0] : 8'h00;
    end
  endfunction

  task automatic push(int s, logic [7:0] b);
    srcq[s].push_back(b);
    drive();
  endtask

  task automatic expb(int s, logic [7:0] b);
    exp_t x;
    x.id = 1'(s);
    x.d  = b;
    sb.push_back(x);
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((sb.size() != 0 || busy_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 300), 32'd1);
    step(1);
  endtask

  // Source FIFO model: pop the head on every acknowledged cycle.
  initial begin
    forever begin
      @(negedge clk);
      ack_s = src_ack_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
        if (ack_s[k] && srcq[k].size() > 0) srcq[k].delete(0);
      drive();
    end
  end

  // Monitor: every byte the UART takes must match the scoreboard head.
  always @(negedge clk) begin
    if (reset_i) begin
      if (src_ack_o[0]) ack_cnt[0]++;
      if (src_ack_o[1]) ack_cnt[1]++;
      if (uart_rts_o && uart_next_i) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("uart_byte", {23'd0, grant_id_o, uart_d_o},
                {23'd0, e.id, e.d});
          check("ack_onehot", 32'(src_ack_o), 32'(2'b01 << e.id));
        end
      end else if (src_ack_o != 2'b00) begin
        check("spurious_ack", 32'(src_ack_o), 32'd0);
      end
    end
  end

  int a0;

  initial begin
    reset_i       = 1'b0;
    uart_next_i   = 1'b1;
    overrun_clr_i = 1'b0;
    stall         = 2'b00;
    ack_cnt[0]    = 0;
    ack_cnt[1]    = 0;
    drive();

    // T1: reset and quiet idle
    step(3);
    @(negedge clk);
    check("t1_rst_outs",
          {uart_d_o, uart_rts_o, src_ack_o, grant_id_o, busy_o, overrun_o},
          32'd0);
    step(1);
    reset_i = 1'b1;
    step(4);
    @(negedge clk);
    check("t1_idle_outs",
          {uart_d_o, uart_rts_o, src_ack_o, grant_id_o, busy_o, overrun_o},
          32'd0);
    step(1);

    // T2: single frame from src0
    a0 = ack_cnt[0];
    expb(0, 8'h11); expb(0, 8'h22); expb(0, 8'h00);
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h00);
    drain("t2_drain");
    check("t2_ack_cycles", 32'(ack_cnt[0] - a0), 32'd3);
    check("t2_busy_low", 32'(busy_o), 32'd0);

    // T3: both sources stream; last grant was 0 so src1 goes first
    foreach (srcq[k]) srcq[k].delete();
    expb(1, 8'hb1); expb(1, 8'hb2); expb(1, 8'h00);
    expb(0, 8'ha1); expb(0, 8'ha2); expb(0, 8'h00);
    expb(1, 8'hb3); expb(1, 8'hb4); expb(1, 8'h00);
    expb(0, 8'ha3); expb(0, 8'ha4); expb(0, 8'h00);
    push(0, 8'ha1); push(0, 8'ha2); push(0, 8'h00);
    push(0, 8'ha3); push(0, 8'ha4); push(0, 8'h00);
    push(1, 8'hb1); push(1, 8'hb2); push(1, 8'h00);
    push(1, 8'hb3); push(1, 8'hb4); push(1, 8'h00);
    drain("t3_drain");

    // T4: src1 stalls mid-frame while src0 waits
    expb(1, 8'h55);
    push(1, 8'h55);
    step(2);
    expb(1, 8'h66); expb(1, 8'h00);
    expb(0, 8'hc1); expb(0, 8'h00);
    push(0, 8'hc1); push(0, 8'h00);
    repeat (5) begin
      @(negedge clk);
      check("t4_stall", {uart_rts_o, src_ack_o, grant_id_o, busy_o},
            {27'd0, 1'b0, 2'b00, 1'b1, 1'b1});
    end
    step(1);
    push(1, 8'h66); push(1, 8'h00);
    drain("t4_drain");
    check("t4_no_ovr", 32'(overrun_o), 32'd0);

    // T5: runaway frame, watchdog at 4 bytes
    expb(0, 8'h01); expb(0, 8'h02); expb(0, 8'h03); expb(0, 8'h04);
    expb(1, 8'hd1); expb(1, 8'h00);
    expb(0, 8'h05); expb(0, 8'h00);
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
    push(0, 8'h04); push(0, 8'h05); push(0, 8'h00);
    step(1);
    push(1, 8'hd1); push(1, 8'h00);
    drain("t5_drain");
    check("t5_ovr_set", 32'(overrun_o), 32'd1);
    overrun_clr_i = 1'b1;
    step(1);
    overrun_clr_i = 1'b0;
    @(negedge clk);
    check("t5_ovr_clr", 32'(overrun_o), 32'd0);
    step(1);

    // T6: asynchronous reset mid-frame
    expb(1, 8'he1);
    push(1, 8'he1); push(1, 8'he2); push(1, 8'h00);
    step(2);
    #1;
    reset_i = 1'b0;
    #1;
    check("t6_async_rst", {uart_rts_o, src_ack_o, busy_o, grant_id_o},
          32'd0);
    sb.delete();
    foreach (srcq[k]) srcq[k].delete();
    drive();
    step(2);
    reset_i = 1'b1;
    step(1);
    expb(0, 8'hf1); expb(0, 8'h00);
    expb(1, 8'h91); expb(1, 8'h00);
    push(1, 8'h91); push(1, 8'h00);
    push(0, 8'hf1); push(0, 8'h00);
    drain("t6_drain");
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
